// File: rtl/neopixel_pkg.sv
// Shared WS2812 timing constants and receiver state encoding; the transmitter uses the same
// constants so loopback timing has a single source.
package neopixel_pkg;

  // Bit cell timing in 10 MHz system clock cycles
  localparam int NP_T0H        = 3;
  localparam int NP_T1H        = 6;
  localparam int NP_T0L        = 9;
  localparam int NP_T1L        = 6;
  localparam int NP_TRESET     = 500;
  localparam int NP_NUM_PIXELS = 8;
  localparam int NP_BIT_THRESH = 5;
  localparam int NP_MIN_HIGH   = 2;
  localparam int NP_MAX_HIGH   = 20;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } rx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/neopixel_rx_if.sv
// Pixel RAM write port and frame status produced by the WS2812 receiver.
interface neopixel_rx_if;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [23:0] o_mem_data;
  logic        o_frame_done;
  logic [7:0]  o_pixel_count;
  logic        o_err;

  modport master (
    output o_mem_we, o_mem_addr, o_mem_data, o_frame_done, o_pixel_count, o_err
  );
  modport slave (
    input  o_mem_we, o_mem_addr, o_mem_data, o_frame_done, o_pixel_count, o_err
  );
endinterface

// File: rtl/neopixel_sync_edge.sv
// 2-FF synchronizer for the async data pin plus registered rise/fall pulses.
// o_lvl is time-aligned with the edge pulses.
module neopixel_sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_din,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] din_pipe;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      din_pipe <= '0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
    end else begin
      din_pipe <= {din_pipe[1:0], i_din};
      o_rise   <= din_pipe[1] & ~din_pipe[2];
      o_fall   <= ~din_pipe[1] & din_pipe[2];
    end
  end

  assign o_lvl = din_pipe[2];
endmodule

// File: rtl/neopixel_rx.sv
// WS2812 receiver: classifies high pulses by width, assembles GRB words MSB-first, writes
// completed pixels to RAM and reports end-of-frame on the latch gap.
module neopixel_rx
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS    = NP_NUM_PIXELS,
  parameter int BIT_THRESH    = NP_BIT_THRESH,
  parameter int MIN_HIGH      = NP_MIN_HIGH,
  parameter int MAX_HIGH      = NP_MAX_HIGH,
  parameter int TRESET_CYCLES = NP_TRESET
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_din,
  neopixel_rx_if.master bus
);
  localparam logic [15:0] THRESH_W = 16'(BIT_THRESH);
  localparam logic [15:0] MIN_W    = 16'(MIN_HIGH);
  localparam logic [15:0] MAX_W    = 16'(MAX_HIGH);
  localparam logic [15:0] TRESET_W = 16'(TRESET_CYCLES);
  localparam logic [7:0]  NPIX_W   = 8'(NUM_PIXELS);

  rx_state_t   state, state_n;
  logic        din_lvl, din_rise, din_fall;
  logic [15:0] cnt;
  logic [22:0] shreg;
  logic [23:0] word_n;
  logic [4:0]  bit_idx;
  logic [7:0]  pixel_idx;
  logic        new_frame, shift_en, glitch, abort, frame_end;

  logic        mem_we_q, frame_done_q, err_q;
  logic [7:0]  mem_addr_q, pixel_count_q;
  logic [23:0] mem_data_q;

  neopixel_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (i_din),
    .o_lvl   (din_lvl),
    .o_rise  (din_rise),
    .o_fall  (din_fall)
  );

  // Width counter restarts at 1 on every edge, so at an edge it holds the width just ended
  always_ff @(posedge i_clk) begin
    if (i_reset)                cnt <= '0;
    else if (din_rise | din_fall) cnt <= 16'd1;
    else                        cnt <= sat_inc16(cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_SYNC;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_SYNC: if (!din_lvl && cnt >= TRESET_W) state_n = S_IDLE;
      S_IDLE: if (din_rise) state_n = S_HIGH;
      S_HIGH: begin
        if (cnt >= MAX_W)  state_n = S_SYNC;
        else if (din_fall) state_n = S_LOW;
      end
      S_LOW: begin
        if (cnt >= TRESET_W) state_n = S_IDLE;
        else if (din_rise)   state_n = S_HIGH;
      end
      default: state_n = S_SYNC;
    endcase
  end

  always_comb begin
    new_frame = 1'b0;
    shift_en  = 1'b0;
    glitch    = 1'b0;
    abort     = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: new_frame = din_rise;
      S_HIGH: begin
        abort    = (cnt >= MAX_W);
        shift_en = !abort && din_fall && (cnt >= MIN_W);
        glitch   = !abort && din_fall && (cnt < MIN_W);
      end
      S_LOW:   frame_end = (cnt >= TRESET_W);
      default: ;
    endcase
  end

  assign word_n = {shreg, (cnt >= THRESH_W)};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg         <= '0;
      bit_idx       <= '0;
      pixel_idx     <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      frame_done_q  <= 1'b0;
      pixel_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (new_frame) begin
        err_q     <= 1'b0;
        bit_idx   <= '0;
        pixel_idx <= '0;
      end
      if (glitch) err_q <= 1'b1;
      if (shift_en) begin
        shreg <= word_n[22:0];
        if (bit_idx == 5'd23) begin
          bit_idx <= '0;
          // Past the RAM size: drop the pixel, keep decoding to frame end
          if (pixel_idx < NPIX_W) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= pixel_idx;
            mem_data_q <= word_n;
            pixel_idx  <= pixel_idx + 8'd1;
          end else begin
            err_q <= 1'b1;
          end
        end else begin
          bit_idx <= bit_idx + 5'd1;
        end
      end
      if (abort) begin
        err_q         <= 1'b1;
        frame_done_q  <= 1'b1;
        pixel_count_q <= pixel_idx;
      end
      if (frame_end) begin
        frame_done_q  <= 1'b1;
        pixel_count_q <= pixel_idx;
        if (bit_idx != 5'd0) err_q <= 1'b1;
      end
    end
  end

  assign bus.o_mem_we      = mem_we_q;
  assign bus.o_mem_addr    = mem_addr_q;
  assign bus.o_mem_data    = mem_data_q;
  assign bus.o_frame_done  = frame_done_q;
  assign bus.o_pixel_count = pixel_count_q;
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx: a bit-level model pushes expected RAM writes and frame
// results as the line is driven; a monitor pops and compares when the receiver reports.
module tb_neopixel_rx;
  import neopixel_pkg::*;

  typedef struct packed { logic [7:0] addr; logic [23:0] data; } wr_t;
  typedef struct packed { logic [7:0] cnt;  logic err; }         frm_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic i_din   = 1'b0;

  neopixel_rx_if bus ();

  neopixel_rx dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   (i_din),
    .bus     (bus)
  );

  always #50 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t  wr_q[$];
  frm_t frm_q[$];

  int          m_pix;
  int          m_bits;
  bit          m_err;
  logic [23:0] m_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every write strobe / frame pulse must match the oldest expectation
  always @(negedge i_clk) begin
    if (!i_reset && bus.o_mem_we === 1'b1) begin
      chk("wr_pend", {31'b0, wr_q.size() != 0}, 32'd1);
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", {24'b0, bus.o_mem_addr}, {24'b0, e.addr});
        chk("wr_data", {8'b0, bus.o_mem_data}, {8'b0, e.data});
      end
    end
    if (!i_reset && bus.o_frame_done === 1'b1) begin
      chk("frm_pend", {31'b0, frm_q.size() != 0}, 32'd1);
      if (frm_q.size() != 0) begin
        frm_t f;
        f = frm_q.pop_front();
        chk("frm_cnt", {24'b0, bus.o_pixel_count}, {24'b0, f.cnt});
        chk("frm_err", {31'b0, bus.o_err}, {31'b0, f.err});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    i_din = v;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic frame_start();
    m_pix  = 0;
    m_bits = 0;
    m_err  = 1'b0;
    m_word = '0;
  endtask

  task automatic model_bit(input bit b);
    m_word = {m_word[22:0], b};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (m_pix < NP_NUM_PIXELS) begin
        wr_q.push_back({8'(m_pix), m_word});
        m_pix++;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic drive_bit(input bit b);
    hold(1'b1, b ? NP_T1H : NP_T0H);
    hold(1'b0, b ? NP_T1L : NP_T0L);
  endtask

  task automatic tx_bit(input bit b);
    model_bit(b);
    drive_bit(b);
  endtask

  task automatic tx_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) tx_bit(w[i]);
  endtask

  task automatic pulse(input int hi, input int lo, input bit b);
    model_bit(b);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic latch(input int n);
    frm_q.push_back({8'(m_pix), m_err | (m_bits != 0)});
    hold(1'b0, n);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_we"},   {31'b0, bus.o_mem_we},      32'd0);
    chk({pfx, "_addr"}, {24'b0, bus.o_mem_addr},    32'd0);
    chk({pfx, "_data"}, {8'b0,  bus.o_mem_data},    32'd0);
    chk({pfx, "_done"}, {31'b0, bus.o_frame_done},  32'd0);
    chk({pfx, "_cnt"},  {24'b0, bus.o_pixel_count}, 32'd0);
    chk({pfx, "_err"},  {31'b0, bus.o_err},         32'd0);
  endtask

  initial begin
    logic [23:0] w;
    repeat (3) @(negedge i_clk);
    chk_zero_outputs("rst");
    i_reset = 1'b0;
    hold(1'b0, 600);

    // 1: single pixel
    frame_start();
    tx_word(24'hFF00A5);
    latch(600);

    // 2: eight pixels, full RAM
    frame_start();
    for (int i = 0; i < 8; i++) begin
      w = 24'(32'h010203 * i);
      tx_word(w);
    end
    latch(600);

    // 3: ten pixels, overflow
    frame_start();
    for (int i = 0; i < 10; i++) begin
      w = 24'(32'h111111 * (i + 1));
      tx_word(w);
    end
    latch(600);

    // 4: pixel plus six trailing bits
    frame_start();
    tx_word(24'h5A5A5A);
    for (int i = 0; i < 6; i++) tx_bit(i[0]);
    latch(500);

    // 5: glitch mid-pixel, then overlong high aborts into resync
    frame_start();
    w = 24'h123456;
    for (int i = 23; i >= 14; i--) tx_bit(w[i]);
    m_err = 1'b1;
    hold(1'b1, 1);
    hold(1'b0, 9);
    for (int i = 13; i >= 0; i--) tx_bit(w[i]);
    m_err = 1'b1;
    frm_q.push_back({8'(m_pix), 1'b1});
    hold(1'b1, 25);
    hold(1'b0, 10);
    for (int i = 0; i < 24; i++) drive_bit(1'b1);
    hold(1'b0, 600);

    // 6: reset at bit 12, junk ignored until line idles, then clean pixel
    frame_start();
    for (int i = 0; i < 12; i++) tx_bit(1'b1);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk_zero_outputs("midrst");
    i_reset = 1'b0;
    for (int i = 0; i < 12; i++) drive_bit(1'b1);
    hold(1'b0, 600);
    frame_start();
    tx_word(24'h00FF00);
    latch(600);

    // 7: width boundaries: high 4 -> 0, high 5 -> 1, 499-cycle low does not end frame
    frame_start();
    w = 24'hA53C96;
    for (int i = 0; i < 24; i++) begin
      pulse(w[23 - i] ? 5 : 4, (i == 11) ? 499 : 8, w[23 - i]);
    end
    latch(600);

    for (int i = 0; i < 2000 && (wr_q.size() != 0 || frm_q.size() != 0); i++)
      @(negedge i_clk);
    chk("wr_left",  32'(wr_q.size()),  32'd0);
    chk("frm_left", 32'(frm_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
